// File: rtl/decodificador_de_teclado.sv
`default_nettype none
// ============================================================================
// Module   : decodificador_de_teclado
// Purpose  : 4x4 matrix keypad scanner and decoder. Drives one row low at a
//            time, samples the active-low columns through a 2-flop
//            synchronizer, debounces press and release, and presents the hex
//            code of the accepted key with a level-valid flag.
// Ports    : clk          system clock
//            rst          asynchronous active-high reset
//            col_matriz   [3:0] column lines, active-low, asynchronous input
//            lin_matriz   [3:0] row drive, active-low, one-hot-low
//            tecla_value  [3:0] code of the last accepted key
//            tecla_valid        high while a debounced key is held
// Revision : 1.0 - initial release
// ============================================================================
module decodificador_de_teclado #(
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int SCAN_DWELL      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_matriz,
  output logic [3:0] lin_matriz,
  output logic [3:0] tecla_value,
  output logic       tecla_valid
);

  localparam int c_dwell_w = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
  localparam int c_deb_w   = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(SCAN_DWELL - 1);
  localparam logic [c_deb_w-1:0]   c_deb_last   = c_deb_w'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    PRESSED   = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  state_t               r_state;
  logic [3:0]           r_col_meta;
  logic [3:0]           r_col_s;
  logic [1:0]           r_row;
  logic [1:0]           r_col_idx;
  logic [c_dwell_w-1:0] r_dwell;
  logic [c_deb_w-1:0]   r_deb;

  logic [3:0] w_low;
  logic       w_single;
  logic       w_idle;
  logic [1:0] w_col_idx;

  // Exactly one column low: non-zero and a power of two.
  assign w_low    = ~r_col_s;
  assign w_single = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
  assign w_idle   = (r_col_s == 4'hF);

  always_comb begin
    w_col_idx = 2'd0;
    case (w_low)
      4'b0001: w_col_idx = 2'd0;
      4'b0010: w_col_idx = 2'd1;
      4'b0100: w_col_idx = 2'd2;
      4'b1000: w_col_idx = 2'd3;
      default: w_col_idx = 2'd0;
    endcase
  end

  function automatic logic [3:0] f_row_drive(input logic [1:0] row);
    f_row_drive = ~(4'b0001 << row);
  endfunction

  function automatic logic [3:0] f_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] k;
    case ({row, col})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hF;
      4'b11_01: k = 4'h0;
      4'b11_10: k = 4'hE;
      default:  k = 4'hD;
    endcase
    f_key = k;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SCAN;
      r_col_meta  <= 4'hF;
      r_col_s     <= 4'hF;
      r_row       <= 2'd0;
      r_col_idx   <= 2'd0;
      r_dwell     <= '0;
      r_deb       <= '0;
      lin_matriz  <= 4'b1110;
      tecla_value <= 4'h0;
      tecla_valid <= 1'b0;
    end else begin
      r_col_meta <= col_matriz;
      r_col_s    <= r_col_meta;

      case (r_state)
        SCAN: begin
          // Columns are only trusted in the last dwell cycle, once the row
          // drive has had time to settle through the synchronizer.
          if (r_dwell == c_dwell_last) begin
            r_dwell <= '0;
            if (w_single) begin
              r_col_idx <= w_col_idx;
              r_deb     <= '0;
              r_state   <= DEB_PRESS;
            end else begin
              r_row      <= r_row + 2'd1;
              lin_matriz <= f_row_drive(r_row + 2'd1);
            end
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end

        DEB_PRESS: begin
          if (w_single && (w_col_idx == r_col_idx)) begin
            if (r_deb == c_deb_last) begin
              tecla_value <= f_key(r_row, r_col_idx);
              tecla_valid <= 1'b1;
              r_deb       <= '0;
              r_state     <= PRESSED;
            end else begin
              r_deb <= r_deb + 1'b1;
            end
          end else if (w_single) begin
            // Finger slid to a neighbouring column on the same row.
            r_col_idx <= w_col_idx;
            r_deb     <= '0;
          end else begin
            // Released or ghosting: resume scanning from the same row.
            r_dwell <= '0;
            r_state <= SCAN;
          end
        end

        PRESSED: begin
          if (w_idle) begin
            r_deb   <= '0;
            r_state <= DEB_REL;
          end
        end

        DEB_REL: begin
          if (w_idle) begin
            if (r_deb == c_deb_last) begin
              tecla_valid <= 1'b0;
              r_deb       <= '0;
              r_dwell     <= '0;
              r_state     <= SCAN;
            end else begin
              r_deb <= r_deb + 1'b1;
            end
          end else begin
            r_state <= PRESSED;
          end
        end

        default: r_state <= SCAN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decodificador_de_teclado.sv
`default_nettype none
// ============================================================================
// Module   : tb_decodificador_de_teclado
// Purpose  : Self-checking bench for decodificador_de_teclado. A physical
//            keypad model pulls a column low only while its row is driven;
//            expected key codes come from the printed key layout and timing
//            is checked against windows derived from the debounce/dwell
//            parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decodificador_de_teclado;

  localparam int DEB = 100;
  localparam int DW  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col_matriz;
  logic [3:0] lin_matriz;
  logic [3:0] tecla_value;
  logic       tecla_valid;

  logic [15:0] keys_down;   // bit r*4+c = key at row r, column c is pressed

  int total = 0;
  int bad   = 0;

  // Printed keypad layout, row-major.
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hF, 4'h0, 4'hE, 4'hD};

  always #5 clk = ~clk;

  // Physical switch matrix: a pressed key connects its row to its column.
  always_comb begin
    col_matriz = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!lin_matriz[r] && keys_down[r*4+c]) col_matriz[c] = 1'b0;
  end

  decodificador_de_teclado #(
    .DEBOUNCE_CYCLES(DEB),
    .SCAN_DWELL     (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .col_matriz (col_matriz),
    .lin_matriz (lin_matriz),
    .tecla_value(tecla_value),
    .tecla_valid(tecla_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_row(input int r);
    int n = 0;
    logic [3:0] prev = lin_matriz;
    @(negedge clk);
    while (!(prev[r] && !lin_matriz[r]) && n < 8*DW) begin
      prev = lin_matriz;
      @(negedge clk);
      n++;
    end
    check("row_wait", {31'd0, lin_matriz[r]}, 32'd0);
  endtask

  task automatic press_release(input int r, input int c, input int extra, input bit bounce);
    int n;
    bit dropped;
    keys_down = 16'd1 << (r*4 + c);
    n = 0;
    while (!tecla_valid && n < 4*DW + DEB + 20) begin
      @(negedge clk);
      n++;
    end
    check("rise", {31'd0, tecla_valid}, 32'd1);
    check("rise_not_early", {31'd0, n >= DEB}, 32'd1);
    check("value", {28'd0, tecla_value}, {28'd0, keymap[r*4+c]});
    if (bounce) begin
      dropped = 1'b0;
      keys_down = 16'd0;
      repeat (5) begin @(negedge clk); if (!tecla_valid) dropped = 1'b1; end
      keys_down = 16'd1 << (r*4 + c);
      repeat (20) begin @(negedge clk); if (!tecla_valid) dropped = 1'b1; end
      check("bounce_keeps_valid", {31'd0, dropped}, 32'd0);
    end
    repeat (extra) @(negedge clk);
    keys_down = 16'd0;
    n = 0;
    while (tecla_valid && n < DEB + 20) begin
      @(negedge clk);
      n++;
    end
    check("fall", {31'd0, tecla_valid}, 32'd0);
    check("fall_window", {31'd0, (n >= DEB) && (n <= DEB + 4)}, 32'd1);
    check("value_held", {28'd0, tecla_value}, {28'd0, keymap[r*4+c]});
  endtask

  task automatic glitch(input int r, input int c, input int len);
    bit seen = 1'b0;
    logic [3:0] rows_seen = 4'h0;
    keys_down = 16'd1 << (r*4 + c);
    repeat (len) begin @(negedge clk); if (tecla_valid) seen = 1'b1; end
    keys_down = 16'd0;
    repeat (DEB + 10) begin @(negedge clk); if (tecla_valid) seen = 1'b1; end
    check("glitch_no_valid", {31'd0, seen}, 32'd0);
    repeat (4*DW + 4) begin @(negedge clk); rows_seen |= ~lin_matriz; end
    check("scan_resumes", {28'd0, rows_seen}, 32'hF);
  endtask

  initial begin
    logic [3:0] exp_lin;
    bit seen;
    int r;
    int c;

    keys_down = 16'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_lin", {28'd0, lin_matriz}, 32'hE);
    check("rst_valid", {31'd0, tecla_valid}, 32'd0);
    check("rst_value", {28'd0, tecla_value}, 32'd0);

    // Row k/DW (mod 4) is driven after the k-th clock since reset release.
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      exp_lin = ~(4'b0001 << ((k / DW) % 4));
      check("scan_seq", {28'd0, lin_matriz}, {28'd0, exp_lin});
    end

    // Directed keys: 5, A, glitch on row 2, 0 with release bounce.
    wait_row(1);
    press_release(1, 1, 20, 1'b0);
    wait_row(0);
    press_release(0, 3, 20, 1'b0);
    wait_row(2);
    glitch(2, 2, 10);
    wait_row(3);
    press_release(3, 1, 10, 1'b1);

    // Ghost: two columns on the same row are never accepted.
    keys_down = 16'b0101 << 4;
    seen = 1'b0;
    repeat (4*DW + DEB + 30) begin @(negedge clk); if (tecla_valid) seen = 1'b1; end
    keys_down = 16'd0;
    check("ghost_ignored", {31'd0, seen}, 32'd0);
    check("ghost_value_kept", {28'd0, tecla_value}, 32'h0);
    repeat (10) @(negedge clk);

    // Random keys, holds, bounces and short glitches.
    for (int i = 0; i < 8; i++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      press_release(r, c, int'($urandom_range(0, 30)), bit'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      glitch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(1, 60)));
    end

    // Asynchronous reset while a key is held valid.
    r = int'($urandom_range(0, 3));
    c = int'($urandom_range(0, 3));
    keys_down = 16'd1 << (r*4 + c);
    begin
      int n = 0;
      while (!tecla_valid && n < 4*DW + DEB + 20) begin @(negedge clk); n++; end
    end
    check("pre_reset_valid", {31'd0, tecla_valid}, 32'd1);
    check("pre_reset_value", {28'd0, tecla_value}, {28'd0, keymap[r*4+c]});
    #2 rst = 1'b1;
    #1;
    check("async_rst_lin", {28'd0, lin_matriz}, 32'hE);
    check("async_rst_valid", {31'd0, tecla_valid}, 32'd0);
    check("async_rst_value", {28'd0, tecla_value}, 32'd0);
    keys_down = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
